// File: rtl/hy_cap.sv
// ============================================================================
// hy_cap -- input-capture timer
// ----------------------------------------------------------------------------
// Measures the number of clock cycles between successive rising edges of an
// event line (typically a hyCnt periodic-interrupt output). Each interval is
// latched into cap_out, and a level interrupt is raised until it is
// acknowledged. Captures that land while an interrupt is still pending set a
// sticky overrun flag and can be counted. A free-running interval counter that
// saturates without an edge reports a timeout.
//
// Build option:
//   HY_CAP_OVR_CNT_EN  defined   -> ovr_cnt is a saturating overrun counter.
//                      undefined -> ovr_cnt is tied to 0 and no counter
//                                   register is built. ovr is unaffected.
//
// Parameters:
//   C_WIDTH    width of the interval counter and the capture register
//   OVR_WIDTH  width of the overrun counter
//
// Ports:
//   clk      in   system clock, all logic on the rising edge
//   rst_n    in   asynchronous active-low reset
//   en       in   capture enable; low returns the FSM to IDLE
//   evt_in   in   event line, synchronous to clk
//   ack      in   single-cycle acknowledge; clears pending/overrun
//   cap_out  out  last captured interval, in cycles
//   intr     out  capture pending (level). This is the "int" interrupt
//                 output; "int" is a reserved word in SystemVerilog.
//   ovr      out  sticky: a capture overwrote a pending one
//   ovr_cnt  out  number of overwritten captures (build-option dependent)
//   tmo      out  interval counter has saturated
//
// Every output comes straight from a flop; there is no combinational path
// from any input to any output.
// ============================================================================
module hy_cap #(
    parameter int C_WIDTH   = 32,
    parameter int OVR_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 evt_in,
    input  logic                 ack,
    output logic [C_WIDTH-1:0]   cap_out,
    output logic                 intr,
    output logic                 ovr,
    output logic [OVR_WIDTH-1:0] ovr_cnt,
    output logic                 tmo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [C_WIDTH-1:0] CNT_MAX = '1;

    state_t             state;
    state_t             state_nxt;
    logic               evt_d;
    logic               rise;
    logic [C_WIDTH-1:0] cnt;

    // Per-cycle control strobes decoded from the FSM.
    logic cnt_clear;   // force the counter (and timeout) back to zero
    logic cnt_start;   // load 1: this edge starts a new interval
    logic cnt_step;    // advance the counter by one, saturating
    logic cap_evt;     // latch the finished interval into cap_out

    // ------------------------------------------------------------------------
    // Edge detector
    // ------------------------------------------------------------------------
    // evt_d resets high so that a line already high when reset is released
    // does not look like a fresh rising edge.
    // NOTE: every clocked register uses non-blocking assignments so that all
    // flops sample the values from before the edge, independent of the order
    // in which the always_ff blocks are evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_d <= 1'b1;
        end else begin
            evt_d <= evt_in;
        end
    end

    assign rise = evt_in & ~evt_d;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    // An edge arriving in the same cycle that en rises is seen in IDLE and is
    // therefore dropped; only ARM reacts to the first edge.
    // NOTE: each signal driven from always_comb receives a default value
    // first, so no path through the block leaves it unassigned and no latch
    // is inferred.
    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    state_nxt = ARM;
                ARM:     if (rise) state_nxt = RUN;
                RUN:     state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM: output (control strobe) decode
    // ------------------------------------------------------------------------
    // en low overrides everything in the same cycle: the counter and timeout
    // are cleared and no capture is taken, even if an edge is present.
    always_comb begin
        cnt_clear = 1'b0;
        cnt_start = 1'b0;
        cnt_step  = 1'b0;
        cap_evt   = 1'b0;
        if (!en) begin
            cnt_clear = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt_clear = 1'b1;
                end
                ARM: begin
                    // First edge only opens the measurement window.
                    cnt_start = rise;
                end
                RUN: begin
                    if (rise) begin
                        cap_evt   = 1'b1;
                        cnt_start = 1'b1;
                    end else begin
                        cnt_step  = 1'b1;
                    end
                end
                default: begin
                    cnt_clear = 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Interval counter and timeout flag
    // ------------------------------------------------------------------------
    // The counter is loaded with 1 on the starting edge, so at the next edge
    // it holds exactly the number of cycles between the two edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt_clear) begin
            cnt <= '0;
        end else if (cnt_start) begin
            cnt <= {{(C_WIDTH-1){1'b0}}, 1'b1};
        end else if (cnt_step && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // tmo rises one cycle after cnt first shows all-ones: it is set while
    // stepping from an already-saturated count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo <= 1'b0;
        end else if (cnt_clear || cap_evt) begin
            tmo <= 1'b0;
        end else if (cnt_step && (cnt == CNT_MAX)) begin
            tmo <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Capture register, pending interrupt and sticky overrun
    // ------------------------------------------------------------------------
    // A capture beats a coincident ack: the new interval stays pending, but
    // the ack still clears the overrun status and the collision is not
    // counted as an overrun. ack is honoured whether or not en is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_out <= '0;
            intr    <= 1'b0;
            ovr     <= 1'b0;
        end else if (cap_evt) begin
            cap_out <= cnt;
            intr    <= 1'b1;
            if (ack) begin
                ovr <= 1'b0;
            end else if (intr) begin
                ovr <= 1'b1;
            end
        end else if (ack) begin
            intr <= 1'b0;
            ovr  <= 1'b0;
        end
    end

`ifdef HY_CAP_OVR_CNT_EN
    // ------------------------------------------------------------------------
    // Overrun counter (saturating)
    // ------------------------------------------------------------------------
    localparam logic [OVR_WIDTH-1:0] OVR_MAX = '1;

    logic [OVR_WIDTH-1:0] ovr_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_cnt_q <= '0;
        end else if (ack) begin
            ovr_cnt_q <= '0;
        end else if (cap_evt && intr && (ovr_cnt_q != OVR_MAX)) begin
            ovr_cnt_q <= ovr_cnt_q + 1'b1;
        end
    end

    assign ovr_cnt = ovr_cnt_q;
`else
    assign ovr_cnt = '0;
`endif

endmodule

// File: tb/tb_hy_cap.sv
// ============================================================================
// tb_hy_cap -- directed, scoreboarded bench for hy_cap
// ----------------------------------------------------------------------------
// The DUT is built with a 4-bit interval counter so that saturation is
// reachable in a few cycles while 10-cycle periods still fit. Expected output
// snapshots are queued as stimulus is applied and popped once the DUT has
// responded (one cycle after the sampling edge).
// ============================================================================
module tb_hy_cap;

    localparam int CW = 4;
    localparam int OW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          evt_in;
    logic          ack;
    logic [CW-1:0] cap_out;
    logic          intr;
    logic          ovr;
    logic [OW-1:0] ovr_cnt;
    logic          tmo;

    always #5 clk = ~clk;

    hy_cap #(
        .C_WIDTH   (CW),
        .OVR_WIDTH (OW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .evt_in  (evt_in),
        .ack     (ack),
        .cap_out (cap_out),
        .intr    (intr),
        .ovr     (ovr),
        .ovr_cnt (ovr_cnt),
        .tmo     (tmo)
    );

    typedef struct {
        string         tag;
        logic [CW-1:0] cap;
        logic          intr;
        logic          ovr;
        logic [OW-1:0] oc;
        logic          tmo;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Advance one clock; inputs change and outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One-cycle high pulse on evt_in; the rise is sampled on this tick.
    task automatic send_edge();
        evt_in = 1'b1;
        tick();
        evt_in = 1'b0;
    endtask

    task automatic push_exp(input string tag, input logic [CW-1:0] cap,
                            input logic i, input logic o,
                            input logic [OW-1:0] oc, input logic t);
        exp_t e;
        e.tag  = tag;
        e.cap  = cap;
        e.intr = i;
        e.ovr  = o;
`ifdef HY_CAP_OVR_CNT_EN
        e.oc   = oc;
`else
        e.oc   = '0;
`endif
        e.tmo  = t;
        exp_q.push_back(e);
    endtask

    task automatic cmp(input string tag, input string field,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = exp_q.pop_front();
            cmp(e.tag, "cap_out", 32'(cap_out), 32'(e.cap));
            cmp(e.tag, "intr",    32'(intr),    32'(e.intr));
            cmp(e.tag, "ovr",     32'(ovr),     32'(e.ovr));
            cmp(e.tag, "ovr_cnt", 32'(ovr_cnt), 32'(e.oc));
            cmp(e.tag, "tmo",     32'(tmo),     32'(e.tmo));
        end
    endtask

    initial begin
        int n;

        rst_n  = 1'b1;
        en     = 1'b0;
        evt_in = 1'b0;
        ack    = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        push_exp("reset", 0, 0, 0, 0, 0);
        check_out();

        tick();
        tick();
        rst_n = 1'b1;
        en    = 1'b1;
        tick();                                   // IDLE -> ARM

        // Periodic edges every 10 cycles.
        send_edge();
        push_exp("arm_only", 0, 0, 0, 0, 0);
        check_out();
        wait_cycles(9);
        send_edge();
        push_exp("cap10", 10, 1, 0, 0, 0);
        check_out();

        ack = 1'b1; tick(); ack = 1'b0;
        push_exp("ack_clear", 10, 0, 0, 0, 0);
        check_out();
        wait_cycles(8);
        send_edge();
        push_exp("cap10_again", 10, 1, 0, 0, 0);
        check_out();

        // Three edges without ack: intervals 6, 7, 5.
        ack = 1'b1; tick(); ack = 1'b0;
        wait_cycles(4);
        send_edge();
        push_exp("ovr_e1", 6, 1, 0, 0, 0);
        check_out();
        wait_cycles(6);
        send_edge();
        push_exp("ovr_e2", 7, 1, 1, 1, 0);
        check_out();
        wait_cycles(4);
        send_edge();
        push_exp("ovr_e3", 5, 1, 1, 2, 0);
        check_out();

        // ack coincident with a capture: capture wins, overrun cleared.
        wait_cycles(7);
        ack = 1'b1; evt_in = 1'b1;
        tick();
        ack = 1'b0; evt_in = 1'b0;
        push_exp("ack_with_cap", 8, 1, 0, 0, 0);
        check_out();

        // Saturation: counter is 1 after the edge, 15 after 14 more cycles,
        // tmo visible one cycle later (15 ticks after the edge).
        ack = 1'b1; tick(); ack = 1'b0;
        push_exp("ack_idle_int", 8, 0, 0, 0, 0);
        check_out();
        n = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (tmo) break;
        end
        cmp("tmo_latency", "ticks", 32'(n), 32'd15);
        wait_cycles(3);
        push_exp("tmo_hold", 8, 0, 0, 0, 1);
        check_out();
        send_edge();
        push_exp("sat_cap", 15, 1, 0, 0, 0);
        check_out();

        // Asynchronous reset mid-interval with a capture pending.
        wait_cycles(2);
        #3 rst_n = 1'b0;
        #1;
        push_exp("async_rst", 0, 0, 0, 0, 0);
        check_out();
        evt_in = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;                             // line still high
        wait_cycles(3);                           // IDLE -> ARM, no rise
        evt_in = 1'b0;
        tick();
        send_edge();
        push_exp("post_rst_arm", 0, 0, 0, 0, 0);
        check_out();
        wait_cycles(6);
        send_edge();
        push_exp("post_rst_cap", 7, 1, 0, 0, 0);
        check_out();

        // Drop en for 3 cycles mid-interval; ack while disabled.
        wait_cycles(3);
        en  = 1'b0;
        ack = 1'b1; tick(); ack = 1'b0;
        push_exp("en_low", 7, 0, 0, 0, 0);
        check_out();
        wait_cycles(2);
        en = 1'b1;
        tick();                                   // IDLE -> ARM
        push_exp("en_back", 7, 0, 0, 0, 0);
        check_out();
        send_edge();
        push_exp("en_rearm", 7, 0, 0, 0, 0);
        check_out();
        wait_cycles(8);
        send_edge();
        push_exp("en_cap", 9, 1, 0, 0, 0);
        check_out();

        cmp("scoreboard", "leftover", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
